// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD CMD-line engine
package sd_pkg;
    typedef enum logic [1:0] {RESP_NONE, RESP_48, RESP_136} resp_t;
    typedef enum logic [2:0] {IDLE, TX_SHIFT, TX_HOLD, RESP_WAIT, RESP_SHIFT, RESP_DONE} state_t;
    localparam int CMD_W = 48;
    localparam int R2_W = 136;
    localparam logic [5:0] CMD0 = 6'd0;
    localparam logic [5:0] CMD2 = 6'd2;
    localparam logic [5:0] CMD9 = 6'd9;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // response length implied by the command index
    function automatic resp_t resp_type(input logic [5:0] idx);
        resp_t r;
        r = RESP_48;
        if (idx == CMD0) r = RESP_NONE;
        else if (idx == CMD2 || idx == CMD9) r = RESP_136;
        return r;
    endfunction
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), MSB-first, shared by command and response paths
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk_400k,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);
    logic fb;
    assign fb = bit_in ^ crc[6];
    // clear wins over enable so a frame can restart on the cycle it is cleared
    always_ff @(posedge clk_400k)
        if (clr) crc <= '0;
        else if (en) crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
endmodule

// File: rtl/sd_cmd_line_ctrl.sv
// sd_cmd_line_ctrl: serialises SD command frames on CMD and captures/checks the card response
module sd_cmd_line_ctrl
    import sd_pkg::*;
#(
    parameter int P_NCR_MAX = 64
) (
    input  logic         clk_400k,
    input  logic         rst,
    input  logic [5:0]   CMD_ID,
    input  logic [7:0]   Arg1,
    input  logic [7:0]   Arg2,
    input  logic [7:0]   Arg3,
    input  logic [7:0]   Arg4,
    input  logic         Send_CMD_En,
    output logic         Send_CMD_Complite,
    input  logic         Get_CMD_En,
    output logic         Get_CMD_Complite,
    output logic [47:0]  Responce_R1_R3,
    output logic [135:0] Responce_R2,
    output logic         resp_crc_err,
    output logic         resp_timeout,
    output logic         cmd_out,
    output logic         cmd_oe,
    input  logic         cmd_in
);
    state_t state_q, state_d;
    resp_t rtype_q, rtype_d;
    logic [134:0] sh_q, sh_d;
    logic [7:0] cnt_q, cnt_d;
    logic chk_q, chk_d, send_cpl_q, send_cpl_d, get_cpl_q, get_cpl_d;
    logic err_q, err_d, tmo_q, tmo_d;
    logic [47:0] r1_q, r1_d;
    logic [135:0] r2_q, r2_d;
    logic [6:0] crc;
    logic accept, tx_last, rx_start, rx_last, timeout, crc_clr, crc_en, crc_bit;

    assign accept = state_q == IDLE && Send_CMD_En && !send_cpl_q;
    assign tx_last = state_q == TX_SHIFT && cnt_q == 8'(CMD_W - 1);
    assign rx_start = state_q == RESP_WAIT && !cmd_in;
    assign timeout = state_q == RESP_WAIT && cmd_in && cnt_q == 8'(P_NCR_MAX);
    assign rx_last = state_q == RESP_SHIFT && cnt_q == (rtype_q == RESP_136 ? 8'(R2_W - 1) : 8'(CMD_W - 1));
    assign crc_clr = accept || rx_start;
    assign crc_en = (state_q == TX_SHIFT && cnt_q < 8'd40) ||
                    (state_q == RESP_SHIFT && (rtype_q == RESP_136 ? (cnt_q >= 8'd8 && cnt_q <= 8'd127) : cnt_q <= 8'd39));
    assign crc_bit = state_q == TX_SHIFT ? sh_q[47] : cmd_in;

    sd_crc7 u_crc (
        .clk_400k(clk_400k),
        .clr     (crc_clr),
        .en      (crc_en),
        .bit_in  (crc_bit),
        .crc     (crc)
    );

    // state register
    always_ff @(posedge clk_400k)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;

    // next-state logic; RESP_DONE waits for a full Get handshake so no response is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (accept) state_d = TX_SHIFT;
            TX_SHIFT:   if (tx_last) state_d = rtype_q == RESP_NONE ? TX_HOLD : RESP_WAIT;
            TX_HOLD:    if (!Send_CMD_En) state_d = IDLE;
            RESP_WAIT:  state_d = rx_start ? RESP_SHIFT : timeout ? IDLE : RESP_WAIT;
            RESP_SHIFT: if (rx_last) state_d = RESP_DONE;
            RESP_DONE:  if (get_cpl_q && !Get_CMD_En) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // pin outputs; the CRC field is muxed straight from the running CRC after bit 8
    always_comb begin
        cmd_oe = state_q == TX_SHIFT;
        cmd_out = !cmd_oe ? 1'b1 : cnt_q < 8'd40 ? sh_q[47] : cnt_q < 8'd47 ? crc[3'(8'd46 - cnt_q)] : 1'b1;
    end

    // datapath next-state: one shift register serves both TX frame and RX capture
    always_comb begin
        rtype_d = accept ? resp_type(CMD_ID) : rtype_q;
        chk_d = accept ? CMD_ID != CMD41 : chk_q;
        sh_d = accept ? {87'd0, 2'b01, CMD_ID, Arg1, Arg2, Arg3, Arg4, 8'h01} :
               state_q == TX_SHIFT ? sh_q << 1 :
               (rx_start || state_q == RESP_SHIFT) ? {sh_q[133:0], cmd_in} : sh_q;
        cnt_d = accept ? 8'd0 :
                state_q == TX_SHIFT ? (tx_last ? 8'd0 : cnt_q + 8'd1) :
                state_q == RESP_WAIT ? (rx_start ? 8'd1 : cnt_q + 8'd1) :
                state_q == RESP_SHIFT ? cnt_q + 8'd1 : cnt_q;
        r1_d = rx_last && rtype_q == RESP_48 ? {sh_q[46:0], cmd_in} : r1_q;
        r2_d = rx_last && rtype_q == RESP_136 ? {sh_q, cmd_in} : r2_q;
        err_d = rx_last ? chk_q && crc != sh_q[6:0] : err_q;
        tmo_d = accept ? 1'b0 : timeout ? 1'b1 : tmo_q;
        send_cpl_d = tx_last || (send_cpl_q && Send_CMD_En);
        get_cpl_d = state_q == RESP_DONE && Get_CMD_En;
    end

    // datapath registers
    always_ff @(posedge clk_400k)
        if (rst) begin
            rtype_q <= RESP_NONE;
            chk_q <= 1'b0;
            sh_q <= '0;
            cnt_q <= '0;
            r1_q <= '0;
            r2_q <= '0;
            err_q <= 1'b0;
            tmo_q <= 1'b0;
            send_cpl_q <= 1'b0;
            get_cpl_q <= 1'b0;
        end else begin
            rtype_q <= rtype_d;
            chk_q <= chk_d;
            sh_q <= sh_d;
            cnt_q <= cnt_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
            err_q <= err_d;
            tmo_q <= tmo_d;
            send_cpl_q <= send_cpl_d;
            get_cpl_q <= get_cpl_d;
        end

    assign Send_CMD_Complite = send_cpl_q;
    assign Get_CMD_Complite = get_cpl_q;
    assign Responce_R1_R3 = r1_q;
    assign Responce_R2 = r2_q;
    assign resp_crc_err = err_q;
    assign resp_timeout = tmo_q;
endmodule

// File: tb/tb_sd_cmd_line_ctrl.sv
// tb_sd_cmd_line_ctrl: scoreboard bench with a simple SD card model on the CMD line
module tb_sd_cmd_line_ctrl;
    localparam int NCR = 64;

    logic clk_400k = 1'b0, rst = 1'b1;
    logic [5:0] CMD_ID = '0;
    logic [7:0] Arg1 = '0, Arg2 = '0, Arg3 = '0, Arg4 = '0;
    logic Send_CMD_En = 1'b0, Get_CMD_En = 1'b0, cmd_in = 1'b1;
    logic Send_CMD_Complite, Get_CMD_Complite, resp_crc_err, resp_timeout, cmd_out, cmd_oe;
    logic [47:0] Responce_R1_R3;
    logic [135:0] Responce_R2;

    typedef struct {
        logic [135:0] v;
        logic err;
        bit wide;
    } exp_t;
    exp_t rsp_q[$];
    logic [47:0] frm_q[$];
    logic [47:0] r1_e = '0;
    logic [135:0] r2_e = '0;
    int n_vec = 0, n_bad = 0;

    always #5 clk_400k = ~clk_400k;

    sd_cmd_line_ctrl #(.P_NCR_MAX(NCR)) dut (
        .clk_400k(clk_400k), .rst(rst), .CMD_ID(CMD_ID),
        .Arg1(Arg1), .Arg2(Arg2), .Arg3(Arg3), .Arg4(Arg4),
        .Send_CMD_En(Send_CMD_En), .Send_CMD_Complite(Send_CMD_Complite),
        .Get_CMD_En(Get_CMD_En), .Get_CMD_Complite(Get_CMD_Complite),
        .Responce_R1_R3(Responce_R1_R3), .Responce_R2(Responce_R2),
        .resp_crc_err(resp_crc_err), .resp_timeout(resp_timeout),
        .cmd_out(cmd_out), .cmd_oe(cmd_oe), .cmd_in(cmd_in)
    );

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int lo);
        logic [6:0] c;
        logic f;
        c = '0;
        for (int i = hi; i >= lo; i--) begin
            f = v[i] ^ c[6];
            c = {c[5:0], 1'b0};
            if (f) c = c ^ 7'b0001001;
        end
        return c;
    endfunction

    function automatic logic [47:0] mkframe(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] t;
        t = {88'd0, 2'b01, idx, arg, 8'h01};
        t[7:1] = crc7(t, 47, 8);
        return t[47:0];
    endfunction

    // rlen: 0 none, 48/136 response bits, -1 silent card; gap: idle cycles before start bit
    // gmode: 0 Get raised with Send, 1 raised mid-capture, 2 raised well after capture
    task automatic run_cmd(input string nm, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [47:0] frm_e, input int rlen, input logic [135:0] rsp,
                           input logic err_e, input int gap, input int gmode);
        logic [47:0] got;
        int oe_n;
        bit ok;
        exp_t e;
        got = '0;
        oe_n = 0;
        ok = 0;
        frm_q.push_back(frm_e);
        CMD_ID = idx;
        {Arg1, Arg2, Arg3, Arg4} = arg;
        Send_CMD_En = 1'b1;
        Get_CMD_En = gmode == 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk_400k);
            ok = cmd_oe;
        end
        chk({nm, "_accept"}, 136'(ok), 136'd1);
        if (!ok) begin
            Send_CMD_En = 1'b0;
            Get_CMD_En = 1'b0;
            frm_q.delete();
            return;
        end
        for (int i = 47; i >= 0; i--) begin
            if (i != 47) @(negedge clk_400k);
            got[i] = cmd_out;
            oe_n += int'(cmd_oe);
        end
        chk({nm, "_cpl_c48"}, 136'(Send_CMD_Complite), 136'd0);
        chk({nm, "_frame"}, 136'(got), 136'(frm_q.pop_front()));
        chk({nm, "_oe_cycles"}, 136'(oe_n), 136'd48);
        @(negedge clk_400k);
        chk({nm, "_cpl_c49"}, 136'(Send_CMD_Complite), 136'd1);
        chk({nm, "_oe_c49"}, 136'({cmd_oe, cmd_out}), 136'b01);
        Send_CMD_En = 1'b0;
        if (rlen == 0) begin
            repeat (2) @(negedge clk_400k);
            chk({nm, "_cpl_clr"}, 136'(Send_CMD_Complite), 136'd0);
            return;
        end
        if (rlen < 0) begin
            repeat (NCR) @(negedge clk_400k);
            chk({nm, "_tmo_early"}, 136'(resp_timeout), 136'd0);
            @(negedge clk_400k);
            chk({nm, "_tmo"}, 136'(resp_timeout), 136'd1);
            Get_CMD_En = 1'b1;
            repeat (4) @(negedge clk_400k);
            chk({nm, "_get_cpl"}, 136'(Get_CMD_Complite), 136'd0);
            Get_CMD_En = 1'b0;
            return;
        end
        rsp_q.push_back('{v: rsp, err: err_e, wide: rlen == 136});
        repeat (gap) @(negedge clk_400k);
        for (int i = rlen - 1; i >= 0; i--) begin
            cmd_in = rsp[i];
            if (gmode == 1 && i == rlen / 2) Get_CMD_En = 1'b1;
            @(negedge clk_400k);
        end
        cmd_in = 1'b1;
        if (gmode == 2) begin
            repeat (3) @(negedge clk_400k);
            chk({nm, "_get_cpl_idle"}, 136'(Get_CMD_Complite), 136'd0);
            Get_CMD_En = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk_400k);
            ok = Get_CMD_Complite;
        end
        chk({nm, "_get_cpl"}, 136'(ok), 136'd1);
        e = rsp_q.pop_front();
        if (e.wide) r2_e = e.v;
        else r1_e = e.v[47:0];
        chk({nm, "_r1"}, 136'(Responce_R1_R3), 136'(r1_e));
        chk({nm, "_r2"}, Responce_R2, r2_e);
        chk({nm, "_crc_err"}, 136'(resp_crc_err), 136'(e.err));
        Get_CMD_En = 1'b0;
        repeat (2) @(negedge clk_400k);
        chk({nm, "_get_cpl_clr"}, 136'(Get_CMD_Complite), 136'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [119:0] cid;
        logic [135:0] r2v, r2b;
        bit ok;
        cid = 120'h0353445344333280123456780129AB;
        r2v = {8'h3F, cid, 8'h01};
        r2v[7:1] = crc7(r2v, 127, 8);
        r2b = r2v ^ (136'd1 << 60);
        repeat (3) @(negedge clk_400k);
        chk("rst_oe_out", 136'({cmd_oe, cmd_out}), 136'b01);
        chk("rst_cpl", 136'({Send_CMD_Complite, Get_CMD_Complite}), 136'd0);
        chk("rst_flags", 136'({resp_crc_err, resp_timeout}), 136'd0);
        chk("rst_r1", 136'(Responce_R1_R3), 136'd0);
        chk("rst_r2", Responce_R2, 136'd0);
        rst = 1'b0;
        @(negedge clk_400k);
        run_cmd("cmd0", 6'd0, 32'h0, 48'h400000000095, 0, '0, 1'b0, 0, 2);
        run_cmd("cmd8", 6'd8, 32'h000001AA, 48'h48000001AA87, 48, 136'h08000001AA13, 1'b0, 0, 2);
        run_cmd("cmd41", 6'd41, 32'h40FF8000, mkframe(6'd41, 32'h40FF8000), 48, 136'h3FC0FF8000FF, 1'b0, 3, 1);
        chk("r3_busy", 136'(Responce_R1_R3[39]), 136'd1);
        run_cmd("cmd2", 6'd2, 32'h0, mkframe(6'd2, 32'h0), 136, r2v, 1'b0, 4, 0);
        run_cmd("cmd9_bad", 6'd9, 32'h12340000, mkframe(6'd9, 32'h12340000), 136, r2b, 1'b1, 2, 2);
        run_cmd("cmd55", 6'd55, 32'h0, mkframe(6'd55, 32'h0), -1, '0, 1'b0, 0, 0);
        CMD_ID = 6'd17;
        {Arg1, Arg2, Arg3, Arg4} = 32'hDEADBEEF;
        Send_CMD_En = 1'b1;
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk_400k);
            ok = cmd_oe;
        end
        chk("abort_accept", 136'(ok), 136'd1);
        repeat (19) @(negedge clk_400k);
        chk("abort_mid_oe", 136'({cmd_oe, resp_timeout}), 136'b10);
        rst = 1'b1;
        Send_CMD_En = 1'b0;
        @(negedge clk_400k);
        chk("abort_oe_out", 136'({cmd_oe, cmd_out}), 136'b01);
        chk("abort_cpl", 136'({Send_CMD_Complite, Get_CMD_Complite}), 136'd0);
        chk("abort_flags", 136'({resp_crc_err, resp_timeout}), 136'd0);
        chk("abort_r1", 136'(Responce_R1_R3), 136'd0);
        chk("abort_r2", Responce_R2, 136'd0);
        rst = 1'b0;
        @(negedge clk_400k);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
